// File: rtl/display_pkg.sv
// Shared types and defaults for the display filter select path.
package display_pkg;

    typedef logic [2:0] filter_sel_t;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;

    typedef enum logic [1:0] {
        STABLE_LO,
        COUNT_HI,
        STABLE_HI,
        COUNT_LO
    } db_state_t;

    function automatic filter_sel_t sel_next(filter_sel_t cur, filter_sel_t last);
        return (cur == last) ? filter_sel_t'(0) : cur + filter_sel_t'(1);
    endfunction

    function automatic filter_sel_t sel_prev(filter_sel_t cur, filter_sel_t last);
        return (cur == filter_sel_t'(0)) ? last : cur - filter_sel_t'(1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw pushbutton.
// Emits a single-cycle pulse when a press is accepted.
module button_debounce
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    sync_q;
    db_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    logic btn_s;
    assign btn_s = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Reverting input takes priority over reaching the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    if (btn_s) begin
                        state_q <= COUNT_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                COUNT_HI: begin
                    if (!btn_s) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!btn_s) begin
                        state_q <= COUNT_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                COUNT_LO: begin
                    if (btn_s) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/filter_select_controller.sv
// Steps a pending filter index from the buttons and commits it
// to the datapath only at the start of vertical blanking.
module filter_select_controller
    import display_pkg::*;
#(
    parameter int NUM_FILTERS     = 6,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [2:0]  select_out,
    output logic [2:0]  pending_out,
    output logic        pending_valid_out,
    output logic        commit_out
);

    localparam filter_sel_t   LAST     = filter_sel_t'(NUM_FILTERS - 1);
    localparam logic [9:0]    V_COMMIT = 10'(V_ACTIVE);
    localparam logic [10:0]   H_LIMIT  = 11'(H_ACTIVE);

    logic left_press;
    logic right_press;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .btn_i  (left_in),
        .press_o(left_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .btn_i  (right_in),
        .press_o(right_press)
    );

    filter_sel_t pending_q, pending_d;
    filter_sel_t select_q, select_d;
    logic        commit_q;
    logic        pvalid_q;
    logic        commit_pt;
    logic        do_commit;

    assign commit_pt = (hcount_in == '0) && (hcount_in < H_LIMIT)
                     && (vcount_in == V_COMMIT);

    // Commit decision uses the pre-update pending value.
    always_comb begin
        pending_d = pending_q;
        case ({left_press, right_press})
            2'b01:   pending_d = sel_next(pending_q, LAST);
            2'b10:   pending_d = sel_prev(pending_q, LAST);
            default: pending_d = pending_q;
        endcase
        do_commit = commit_pt && (pending_q != select_q);
        select_d  = do_commit ? pending_q : select_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending_q <= '0;
            select_q  <= '0;
            commit_q  <= 1'b0;
            pvalid_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            select_q  <= select_d;
            commit_q  <= do_commit;
            pvalid_q  <= (pending_d != select_d);
        end
    end

    assign select_out        = select_q;
    assign pending_out       = pending_q;
    assign pending_valid_out = pvalid_q;
    assign commit_out        = commit_q;

endmodule

// File: tb/tb_filter_select_controller.sv
// Directed bench for filter_select_controller with short debounce.
module tb_filter_select_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic [10:0] h = '0;
    logic [9:0]  v = '0;
    logic [2:0]  sel;
    logic [2:0]  pend;
    logic        pv;
    logic        cm;

    int checks = 0;
    int errors = 0;

    filter_select_controller #(
        .NUM_FILTERS    (6),
        .DEBOUNCE_CYCLES(4),
        .H_ACTIVE       (1024),
        .V_ACTIVE       (768)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .left_in          (left),
        .right_in         (right),
        .hcount_in        (h),
        .vcount_in        (v),
        .select_out       (sel),
        .pending_out      (pend),
        .pending_valid_out(pv),
        .commit_out       (cm)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_RIGHT, OP_LEFT, OP_BOTH, OP_BOUNCE, OP_RIGHT7, OP_COMMIT} op_t;

    typedef struct {
        op_t   op;
        int    p;
        int    s;
        int    pvx;
        int    c;
        string nm;
    } vec_t;

    vec_t tbl[14];

    task automatic tick();
        @(posedge clk);
        #1;
        if (h == 11'd1343) begin
            h = '0;
            v = (v == 10'd805) ? 10'd0 : v + 10'd1;
        end else begin
            h = h + 11'd1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic goto(input int hh, input int vv);
        h = 11'(hh);
        v = 10'(vv);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int p, input int s, input int pvx, input int c);
        chk({nm, "_pending"}, 32'(pend), p);
        chk({nm, "_select"}, 32'(sel), s);
        chk({nm, "_pvalid"}, 32'(pv), pvx);
        chk({nm, "_commit"}, 32'(cm), c);
    endtask

    task automatic press(input logic l, input logic r);
        left = l;
        right = r;
        ticks(20);
        left = 1'b0;
        right = 1'b0;
        ticks(10);
    endtask

    task automatic apply(input vec_t t);
        case (t.op)
            OP_RIGHT: press(1'b0, 1'b1);
            OP_LEFT:  press(1'b1, 1'b0);
            OP_BOTH:  press(1'b1, 1'b1);
            OP_BOUNCE: begin
                right = 1'b1;
                ticks(2);
                right = 1'b0;
                ticks(2);
                press(1'b0, 1'b1);
            end
            OP_RIGHT7: repeat (7) press(1'b0, 1'b1);
            default: begin
                goto(0, 768);
                tick();
            end
        endcase
        chk_all(t.nm, t.p, t.s, t.pvx, t.c);
        if (t.op == OP_COMMIT) begin
            tick();
            chk({t.nm, "_pulse_end"}, 32'(cm), 0);
        end
        goto(100, 10);
    endtask

    initial begin
        int bad;

        tbl[0]  = '{OP_LEFT,   5, 0, 1, 0, "left_wrap"};
        tbl[1]  = '{OP_RIGHT,  0, 0, 0, 0, "right_wrap"};
        tbl[2]  = '{OP_COMMIT, 0, 0, 0, 0, "cp_equal"};
        tbl[3]  = '{OP_RIGHT,  1, 0, 1, 0, "right_clean"};
        tbl[4]  = '{OP_COMMIT, 1, 1, 0, 1, "cp_one"};
        tbl[5]  = '{OP_BOUNCE, 2, 1, 1, 0, "bouncy"};
        tbl[6]  = '{OP_BOTH,   2, 1, 1, 0, "both"};
        tbl[7]  = '{OP_COMMIT, 2, 2, 0, 1, "cp_two"};
        tbl[8]  = '{OP_LEFT,   1, 2, 1, 0, "left_a"};
        tbl[9]  = '{OP_LEFT,   0, 2, 1, 0, "left_b"};
        tbl[10] = '{OP_RIGHT7, 1, 2, 1, 0, "right7"};
        tbl[11] = '{OP_COMMIT, 1, 1, 0, 1, "cp_wrap"};
        tbl[12] = '{OP_RIGHT,  2, 1, 1, 0, "right_c"};
        tbl[13] = '{OP_COMMIT, 2, 2, 0, 1, "cp_two_b"};

        goto(100, 10);
        #2 rst = 1'b1;
        ticks(3);
        chk_all("reset", 0, 0, 0, 0);
        rst = 1'b0;
        ticks(2);

        press(1'b0, 1'b1);
        chk_all("pre_rst_press", 1, 0, 1, 0);
        right = 1'b1;
        ticks(3);
        #3 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        right = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(10);
        chk_all("rst_discard", 0, 0, 0, 0);
        goto(0, 768);
        tick();
        chk_all("first_cp", 0, 0, 0, 0);
        goto(100, 10);

        for (int i = 0; i < 14; i++) apply(tbl[i]);

        right = 1'b1;
        ticks(7);
        chk("pre_cp_pending", 32'(pend), 2);
        goto(0, 768);
        tick();
        chk_all("cp_same_cycle", 3, 2, 1, 0);
        tick();
        chk("cp_same_cycle_after", 32'(cm), 0);
        ticks(12);
        right = 1'b0;
        ticks(10);
        goto(0, 768);
        tick();
        chk_all("cp_next_frame", 3, 3, 0, 1);
        goto(100, 10);
        tick();

        for (int f = 0; f < 2; f++) begin
            bad = 0;
            for (int vv = 0; vv < 806; vv++) begin
                goto(0, vv);
                tick();
                if (cm !== 1'b0 || sel !== 3'd3) bad++;
            end
            chk($sformatf("idle_frame%0d_bad_lines", f), 32'(bad), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
